// File: rtl/wb_uart_arbiter_if.sv
// Bus bundle for wb_uart_arbiter: N packed Wishbone masters on one side, the UART slave on the other.
// Signal suffixes are from the arbiter's point of view; the master modport is the environment side.
interface wb_uart_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_WIDTH   = 24
);
    logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*32-1:0]        m_dat_i;
    logic [NUM_MASTERS*4-1:0]         m_sel_i;
    logic [NUM_MASTERS-1:0]           m_we_i;
    logic [NUM_MASTERS-1:0]           m_cyc_i;
    logic [NUM_MASTERS-1:0]           m_stb_i;
    logic [31:0]                      m_dat_o;
    logic [NUM_MASTERS-1:0]           m_ack_o;
    logic [NUM_MASTERS-1:0]           m_err_o;
    logic [ADR_WIDTH-1:0]             s_adr_o;
    logic [31:0]                      s_dat_o;
    logic [3:0]                       s_sel_o;
    logic                             s_we_o;
    logic                             s_cyc_o;
    logic                             s_stb_o;
    logic [31:0]                      s_dat_i;
    logic                             s_ack_i;
    logic                             s_err_i;
    logic                             timeout_o;

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, timeout_o
    );

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, timeout_o
    );
endinterface

// File: rtl/wb_uart_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one UART slave among NUM_MASTERS requesters,
// with a bus timeout that forces an error when the slave never answers.
module wb_uart_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADR_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_uart_arbiter_if.slave bus
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LIMIT = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [ADR_WIDTH-1:0]   adr_arr [NUM_MASTERS];
    logic [31:0]            dat_arr [NUM_MASTERS];
    logic [3:0]             sel_arr [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] ack_vec;
    logic [NUM_MASTERS-1:0] err_vec;

    logic busy;
    logic in_timeout;
    logic ack_fwd;

    assign busy       = (state_q == ST_BUSY);
    assign in_timeout = (state_q == ST_TIMEOUT);
    // Error wins when the slave raises both responses in one cycle.
    assign ack_fwd    = bus.s_ack_i & ~bus.s_err_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign adr_arr[gi] = bus.m_adr_i[gi*ADR_WIDTH +: ADR_WIDTH];
            assign dat_arr[gi] = bus.m_dat_i[gi*32 +: 32];
            assign sel_arr[gi] = bus.m_sel_i[gi*4 +: 4];
            assign req[gi]     = bus.m_cyc_i[gi] & bus.m_stb_i[gi];
            assign ack_vec[gi] = busy & (grant_q == GW'(gi)) & ack_fwd;
            assign err_vec[gi] = (grant_q == GW'(gi)) & ((busy & bus.s_err_i) | in_timeout);
        end
    endgenerate

    // Search starts one past the previous winner so every requester gets a turn.
    logic [GW-1:0] next_grant;
    logic [GW-1:0] cand;
    logic          found;
    int            idx;

    always_comb begin
        next_grant = last_grant_q;
        cand       = '0;
        found      = 1'b0;
        idx        = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx  = (int'(last_grant_q) + i) % NUM_MASTERS;
            cand = GW'(idx);
            if (!found && req[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d      = next_grant;
                    last_grant_d = next_grant;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.s_ack_i || bus.s_err_i) begin
                    state_d = ST_IDLE;
                end else if (!bus.m_cyc_i[grant_q]) begin
                    state_d = ST_IDLE;
                end else if (TO_EN && (cnt_q == CNT_LIMIT)) begin
                    state_d = ST_TIMEOUT;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_TIMEOUT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_MASTERS - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Everything below is gated by state, so an asynchronous reset silences the bus at once.
    assign bus.s_adr_o   = busy ? adr_arr[grant_q] : '0;
    assign bus.s_dat_o   = busy ? dat_arr[grant_q] : '0;
    assign bus.s_sel_o   = busy ? sel_arr[grant_q] : '0;
    assign bus.s_we_o    = busy & bus.m_we_i[grant_q];
    assign bus.s_cyc_o   = busy & bus.m_cyc_i[grant_q];
    assign bus.s_stb_o   = busy & bus.m_stb_i[grant_q];
    assign bus.m_dat_o   = busy ? bus.s_dat_i : '0;
    assign bus.m_ack_o   = ack_vec;
    assign bus.m_err_o   = err_vec;
    assign bus.timeout_o = in_timeout;

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Directed self-checking bench for wb_uart_arbiter with two masters and a 256-cycle timeout.
module tb_wb_uart_arbiter;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    wb_uart_arbiter_if #(.NUM_MASTERS(2), .ADR_WIDTH(24)) bus ();

    wb_uart_arbiter #(
        .NUM_MASTERS(2),
        .ADR_WIDTH(24),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = '0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
    endtask

    task automatic set_master(input int k, input logic [23:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic we);
        bus.m_adr_i[k*24 +: 24] = adr;
        bus.m_dat_i[k*32 +: 32] = dat;
        bus.m_sel_i[k*4 +: 4]   = sel;
        bus.m_we_i[k]           = we;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        set_master(0, 24'hABCDEF, 32'h11111111, 4'hF, 1'b1);
        bus.s_dat_i = 32'hCAFEF00D;
        bus.s_ack_i = 1'b1;
        bus.s_err_i = 1'b1;
        tick();
        vectors++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.timeout_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.timeout_o});
        end
        vectors++;
        if ({bus.m_ack_o, bus.m_err_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_resp: got %b expected 0000", {bus.m_ack_o, bus.m_err_o});
        end
        vectors++;
        if (bus.m_dat_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mdat: got %h expected 00000000", bus.m_dat_o);
        end
        vectors++;
        if (bus.s_adr_o !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_sadr: got %h expected 000000", bus.s_adr_o);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        $display("txn reset: outputs held low during reset");
    endtask

    task automatic test_single_write();
        idle_inputs();
        set_master(0, 24'h000004, 32'h00000041, 4'b0001, 1'b1);
        bus.m_cyc_i = 2'b01;
        bus.m_stb_i = 2'b01;
        settle();
        vectors++;
        if (bus.s_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_idle_cyc: got %b expected 0", bus.s_cyc_o);
        end
        tick();
        vectors++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b111) begin
            miscompares++;
            $display("FAIL wr_ctrl: got %b expected 111", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o});
        end
        vectors++;
        if (bus.s_adr_o !== 24'h000004) begin
            miscompares++;
            $display("FAIL wr_adr: got %h expected 000004", bus.s_adr_o);
        end
        vectors++;
        if (bus.s_dat_o !== 32'h00000041) begin
            miscompares++;
            $display("FAIL wr_dat: got %h expected 00000041", bus.s_dat_o);
        end
        vectors++;
        if (bus.s_sel_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL wr_sel: got %b expected 0001", bus.s_sel_o);
        end
        tick();
        vectors++;
        if (bus.m_ack_o !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_early_ack: got %b expected 00", bus.m_ack_o);
        end
        tick();
        bus.s_ack_i = 1'b1;
        settle();
        vectors++;
        if (bus.m_ack_o !== 2'b01) begin
            miscompares++;
            $display("FAIL wr_ack: got %b expected 01", bus.m_ack_o);
        end
        tick();
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        settle();
        vectors++;
        if ({bus.m_ack_o, bus.s_cyc_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_after: got ack=%b cyc=%b expected 00/0", bus.m_ack_o, bus.s_cyc_o);
        end
        $display("txn write m0 adr=000004 dat=00000041 sel=0001");
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack [8];
        exp_ack = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        idle_inputs();
        do_reset();
        set_master(0, 24'h000100, 32'h0, 4'hF, 1'b0);
        set_master(1, 24'h000200, 32'h0, 4'hF, 1'b0);
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tick();
            bus.s_ack_i = 1'b0;
            settle();
            if (bus.s_stb_o) begin
                bus.s_ack_i = 1'b1;
                settle();
            end
            vectors++;
            if (bus.m_ack_o !== exp_ack[c]) begin
                miscompares++;
                $display("FAIL rr_ack[%0d]: got %b expected %b", c, bus.m_ack_o, exp_ack[c]);
            end
        end
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        tick();
        $display("txn round robin: 8 cycles, grants 0,1,0,1");
    endtask

    task automatic test_read_m1();
        idle_inputs();
        set_master(1, 24'h000010, 32'h0, 4'hF, 1'b0);
        bus.m_cyc_i = 2'b10;
        bus.m_stb_i = 2'b10;
        tick();
        bus.s_dat_i = 32'hDEADBEEF;
        bus.s_ack_i = 1'b1;
        settle();
        vectors++;
        if ({bus.s_we_o, bus.s_adr_o} !== {1'b0, 24'h000010}) begin
            miscompares++;
            $display("FAIL rd_req: got we=%b adr=%h expected 0/000010", bus.s_we_o, bus.s_adr_o);
        end
        vectors++;
        if (bus.m_dat_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_dat: got %h expected deadbeef", bus.m_dat_o);
        end
        vectors++;
        if (bus.m_ack_o !== 2'b10) begin
            miscompares++;
            $display("FAIL rd_ack: got %b expected 10", bus.m_ack_o);
        end
        tick();
        idle_inputs();
        settle();
        $display("txn read m1 adr=000010 dat=deadbeef");
    endtask

    task automatic test_timeout();
        int n;
        idle_inputs();
        set_master(0, 24'h000300, 32'h0, 4'hF, 1'b0);
        set_master(1, 24'h000400, 32'h0, 4'hF, 1'b0);
        bus.m_cyc_i = 2'b01;
        bus.m_stb_i = 2'b01;
        tick();
        n = 0;
        while (bus.s_stb_o && n < 400) begin
            n++;
            tick();
        end
        vectors++;
        if (n !== 256) begin
            miscompares++;
            $display("FAIL to_len: got %0d stb cycles expected 256", n);
        end
        vectors++;
        if ({bus.timeout_o, bus.s_cyc_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL to_pulse: got timeout=%b cyc=%b expected 1/0", bus.timeout_o, bus.s_cyc_o);
        end
        bus.s_ack_i = 1'b1;
        settle();
        vectors++;
        if ({bus.m_err_o, bus.m_ack_o} !== 4'b0100) begin
            miscompares++;
            $display("FAIL to_err: got err=%b ack=%b expected 01/00", bus.m_err_o, bus.m_ack_o);
        end
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        tick();
        vectors++;
        if ({bus.timeout_o, bus.m_err_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL to_clear: got timeout=%b err=%b expected 0/00", bus.timeout_o, bus.m_err_o);
        end
        bus.m_cyc_i = 2'b10;
        bus.m_stb_i = 2'b10;
        tick();
        vectors++;
        if (bus.s_adr_o !== 24'h000400) begin
            miscompares++;
            $display("FAIL to_next_adr: got %h expected 000400", bus.s_adr_o);
        end
        bus.s_ack_i = 1'b1;
        settle();
        vectors++;
        if (bus.m_ack_o !== 2'b10) begin
            miscompares++;
            $display("FAIL to_next_ack: got %b expected 10", bus.m_ack_o);
        end
        tick();
        idle_inputs();
        settle();
        $display("txn timeout m0 after %0d cycles, then m1 served", n);
    endtask

    task automatic test_ack_err_abort();
        idle_inputs();
        set_master(0, 24'h000500, 32'h0, 4'hF, 1'b0);
        bus.m_cyc_i = 2'b01;
        bus.m_stb_i = 2'b01;
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_err_i = 1'b1;
        settle();
        vectors++;
        if ({bus.m_ack_o, bus.m_err_o} !== 4'b0001) begin
            miscompares++;
            $display("FAIL both_resp: got ack=%b err=%b expected 00/01", bus.m_ack_o, bus.m_err_o);
        end
        tick();
        idle_inputs();
        set_master(1, 24'h000600, 32'h0, 4'hF, 1'b1);
        bus.m_cyc_i = 2'b10;
        bus.m_stb_i = 2'b10;
        tick();
        vectors++;
        if (bus.s_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy: got cyc=%b expected 1", bus.s_cyc_o);
        end
        tick();
        tick();
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        settle();
        vectors++;
        if ({bus.s_cyc_o, bus.m_ack_o, bus.m_err_o} !== 5'b00000) begin
            miscompares++;
            $display("FAIL abort_drop: got cyc=%b ack=%b err=%b expected 0/00/00", bus.s_cyc_o, bus.m_ack_o, bus.m_err_o);
        end
        tick();
        vectors++;
        if ({bus.timeout_o, bus.m_err_o, bus.m_ack_o} !== 5'b00000) begin
            miscompares++;
            $display("FAIL abort_quiet: got to=%b err=%b ack=%b expected 0/00/00", bus.timeout_o, bus.m_err_o, bus.m_ack_o);
        end
        set_master(0, 24'h000700, 32'h0, 4'hF, 1'b0);
        bus.m_cyc_i = 2'b01;
        bus.m_stb_i = 2'b01;
        tick();
        vectors++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== {1'b1, 24'h000700}) begin
            miscompares++;
            $display("FAIL abort_regrant: got cyc=%b adr=%h expected 1/000700", bus.s_cyc_o, bus.s_adr_o);
        end
        bus.s_ack_i = 1'b1;
        tick();
        idle_inputs();
        settle();
        $display("txn ack+err m0 forwarded as err; m1 aborted mid-busy");
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        set_master(1, 24'h000800, 32'h55AA55AA, 4'hF, 1'b1);
        bus.m_cyc_i = 2'b10;
        bus.m_stb_i = 2'b10;
        tick();
        vectors++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== {1'b1, 24'h000800}) begin
            miscompares++;
            $display("FAIL mid_busy: got cyc=%b adr=%h expected 1/000800", bus.s_cyc_o, bus.s_adr_o);
        end
        bus.s_dat_i = 32'h12345678;
        bus.s_ack_i = 1'b1;
        rst_n = 1'b0;
        settle();
        vectors++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.m_ack_o, bus.m_err_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_rst_ctrl: got %b expected 0000000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.m_ack_o, bus.m_err_o});
        end
        vectors++;
        if ({bus.s_adr_o, bus.s_dat_o, bus.m_dat_o} !== 88'h0) begin
            miscompares++;
            $display("FAIL mid_rst_data: got adr=%h sdat=%h mdat=%h expected 0", bus.s_adr_o, bus.s_dat_o, bus.m_dat_o);
        end
        tick();
        bus.s_ack_i = 1'b0;
        set_master(0, 24'h000900, 32'h0, 4'hF, 1'b0);
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        rst_n = 1'b1;
        settle();
        tick();
        vectors++;
        if ({bus.s_cyc_o, bus.s_adr_o} !== {1'b1, 24'h000900}) begin
            miscompares++;
            $display("FAIL mid_first_grant: got cyc=%b adr=%h expected 1/000900", bus.s_cyc_o, bus.s_adr_o);
        end
        bus.s_ack_i = 1'b1;
        settle();
        vectors++;
        if (bus.m_ack_o !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_first_ack: got %b expected 01", bus.m_ack_o);
        end
        tick();
        idle_inputs();
        settle();
        $display("txn reset mid-busy m1, restart grants m0 first");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_m1();
        test_timeout();
        test_ack_err_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_uart_arbiter.md
Name: wb_uart_arbiter

Overview:
- Round-robin Wishbone classic arbiter that shares the single UART slave port (24-bit address, 32-bit data) of the SoC among NUM_MASTERS requesters, e.g. CPU data port and a debug unit.
- Sits between the masters and the UART slave (DPI UART or the always-error stub).
- Adds a bus timeout so a slave that never acknowledges cannot hang a master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADR_WIDTH, 24, slave address width.
- TIMEOUT_CYCLES, 256, BUSY cycles without ack/err before a timeout error is forced; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  bus clock; all logic on its rising edge.
- wb_rst_n_i  in  1  reset, asynchronous and active-low.
- m_adr_i  in  NUM_MASTERS*ADR_WIDTH  packed master addresses; master k at [k*ADR_WIDTH +: ADR_WIDTH].
- m_dat_i  in  NUM_MASTERS*32  packed master write data.
- m_sel_i  in  NUM_MASTERS*4  packed byte selects.
- m_we_i  in  NUM_MASTERS  write enables.
- m_cyc_i  in  NUM_MASTERS  cycle requests.
- m_stb_i  in  NUM_MASTERS  strobes.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master error.
- s_adr_o  out  ADR_WIDTH  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte select.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.
- timeout_o  out  1  one-cycle pulse when a timeout is forced.

Behaviour:
- Reset (asynchronous, wb_rst_n_i=0) clears state to IDLE, grant to none, timeout counter to 0, and last_grant to NUM_MASTERS-1, so master 0 wins first. While reset is asserted every output is 0, including combinational outputs, which are gated by state.
- Request: req[k] = m_cyc_i[k] & m_stb_i[k].
- IDLE:
  - If any req, register grant = first requesting index after last_grant, cyclically.
  - Go to BUSY, clear the counter, set last_grant = grant.
  - No slave signals are driven in IDLE. Arbitration latency is 1 cycle.
- BUSY, combinational paths:
  - s_adr_o, s_dat_o, s_sel_o and s_we_o mux from master[grant].
  - s_cyc_o = m_cyc_i[grant]; s_stb_o = m_stb_i[grant].
  - m_ack_o[grant] = s_ack_i & ~s_err_i, so err has precedence when the slave asserts both.
  - m_err_o[grant] = s_err_i.
  - m_dat_o = s_dat_i. All other masters see ack=err=0.
- BUSY, exits:
  - On s_ack_i or s_err_i: return to IDLE next cycle. Transfers are single-beat, so there is a mandatory 1-cycle idle gap between transfers.
  - If m_cyc_i[grant] drops before a response (abort): return to IDLE; no ack or err is generated.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 with no response this cycle, go to TIMEOUT.
- TIMEOUT (exactly 1 cycle):
  - s_cyc_o = s_stb_o = 0; m_err_o[grant] = 1; timeout_o = 1.
  - Late s_ack_i/s_err_i in this cycle are ignored.
  - Next state is IDLE.
- Counter sizing and edge cases:
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.
  - A response in the same cycle the counter hits its limit wins over the timeout.
  - With TIMEOUT_CYCLES=0 the counter is unused and the TIMEOUT state is unreachable.
- Requests from non-granted masters are held off with no ack; they are never dropped.
- Reset asserted mid-transfer drops s_cyc_o/s_stb_o immediately (asynchronously). After release, arbitration restarts from master 0.

Test Plan:
- Reset, then master 0 writes adr 0x000004, dat 0x41, sel 4'b0001; slave acks 2 cycles after s_stb_o -> s_* match master 0, m_ack_o=2'b01 for exactly 1 cycle, state returns to IDLE.
- Both masters request continuously with the slave acking after 1 cycle -> grant sequence 0,1,0,1; each master gets an ack every 4 cycles; no double ack.
- Master 1 reads, slave returns s_dat_i=0xDEADBEEF with ack -> m_dat_o=0xDEADBEEF, m_ack_o=2'b10; master 0 sees no ack.
- TIMEOUT_CYCLES=256, slave never responds -> s_stb_o high for 256 cycles, then m_err_o[grant]=1 and timeout_o=1 for 1 cycle, s_cyc_o=0; the next request is granted normally.
- Slave asserts ack and err together -> err only is forwarded. Separately, with the slave never responding, master drops cyc mid-BUSY -> return to IDLE with no ack, no err, no timeout.
- wb_rst_n_i pulsed low during BUSY with master 1 granted -> all outputs 0 within the same cycle; after release with both masters requesting, master 0 is granted first.
